// File: rtl/line_window_pkg.sv
// Shared types and sizing helpers for the 3-row line-window scheduler.
package line_window_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRIME     = 3'd1,
        READ      = 3'd2,
        WAIT_DONE = 3'd3,
        REFILL    = 3'd4,
        FDONE     = 3'd5
    } lw_state_e;

    // Pixels needed to fill all three rows before the first read pass.
    function automatic int prime_pix(input int width);
        return 3 * width;
    endfunction

    // Bits needed to index n distinct values (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_window_sched_if.sv
// Pixel-source, line-buffer and kernel signals of the line-window scheduler.
// master = scheduler side, slave = environment (source, line buffer, kernel).
interface line_window_sched_if #(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int DW     = 8
);
    import line_window_pkg::*;

    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);

    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          lb_wr_en;
    logic [DW-1:0] lb_wr_data;
    logic          lb_rd_en;
    logic [CW-1:0] lb_rd_col;
    logic          kern_ready;
    logic          kern_done;
    logic          win_valid;
    logic [RW-1:0] win_row;

    modport master (
        input  src_valid, src_data, kern_ready, kern_done,
        output src_ready, lb_wr_en, lb_wr_data, lb_rd_en, lb_rd_col, win_valid, win_row
    );

    modport slave (
        output src_valid, src_data, kern_ready, kern_done,
        input  src_ready, lb_wr_en, lb_wr_data, lb_rd_en, lb_rd_col, win_valid, win_row
    );

endinterface

// File: rtl/line_window_ctr.sv
// Up-counter with synchronous load (priority over enable) and a terminal-count flag.
module line_window_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load overrides enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/line_window_sched.sv
// Line-window scheduler: primes a 3-row line buffer, then alternates a
// WIDTH-column read pass to the kernel with 1-row refills, HEIGHT-2 times.
// Optional build macro LINE_WINDOW_SCHED_PERF_EN adds the stall_cycles counter.
module line_window_sched
    import line_window_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int HEIGHT = 5,
    parameter int DW     = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    line_window_sched_if.master bus,
    output logic                busy,
    output logic                frame_done
`ifdef LINE_WINDOW_SCHED_PERF_EN
    ,
    output logic [15:0]         stall_cycles
`endif
);

    localparam int FW = cnt_w(prime_pix(WIDTH));
    localparam int CW = cnt_w(WIDTH);
    localparam int RW = cnt_w(HEIGHT);

    localparam logic [FW-1:0] PRIME_LAST  = FW'(prime_pix(WIDTH) - 1);
    localparam logic [FW-1:0] REFILL_LAST = FW'(WIDTH - 1);
    localparam logic [CW-1:0] COL_LAST    = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(HEIGHT - 3);

    lw_state_e     state_q, state_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic          win_valid_q, win_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          filling_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [FW-1:0] fill_term_s;
    logic [FW-1:0] fill_cnt_s;
    logic          fill_last_s;
    logic [CW-1:0] col_s;
    logic          col_last_s;

    // Strobes decode straight from the registered state so they line up with the data.
    assign filling_s   = (state_q == PRIME) || (state_q == REFILL);
    assign wr_en_s     = filling_s & bus.src_valid;
    assign rd_en_s     = (state_q == READ) & bus.kern_ready;
    assign fill_term_s = (state_q == PRIME) ? PRIME_LAST : REFILL_LAST;

    // Counters sit at zero whenever their phase is not active, so entering a phase starts clean.
    line_window_ctr #(.W(FW)) u_fill_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (abort | ~filling_s),
        .load_val ({FW{1'b0}}),
        .en       (wr_en_s),
        .term_val (fill_term_s),
        .cnt      (fill_cnt_s),
        .at_term  (fill_last_s)
    );

    line_window_ctr #(.W(CW)) u_col_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (abort | (state_q != READ)),
        .load_val ({CW{1'b0}}),
        .en       (rd_en_s),
        .term_val (COL_LAST),
        .cnt      (col_s),
        .at_term  (col_last_s)
    );

    // Next-state, window-row and registered-output decode; abort overrides everything.
    always_comb begin
        state_d   = state_q;
        win_row_d = win_row_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = PRIME;
                    win_row_d = {RW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME, REFILL: begin
                if (wr_en_s && fill_last_s) begin
                    state_d = READ;
                end else begin
                    state_d = state_q;
                end
            end
            READ: begin
                if (rd_en_s && col_last_s) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = READ;
                end
            end
            WAIT_DONE: begin
                if (bus.kern_done && (win_row_q == ROW_LAST)) begin
                    state_d = FDONE;
                end else if (bus.kern_done) begin
                    state_d   = REFILL;
                    win_row_d = win_row_q + RW'(1);
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            FDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            win_row_d = {RW{1'b0}};
        end else begin
            state_d   = state_d;
            win_row_d = win_row_d;
        end

        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == FDONE);
        win_valid_d  = rd_en_s & ~abort;
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            win_row_q    <= {RW{1'b0}};
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_row_q    <= win_row_d;
            win_valid_q  <= win_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.src_ready  = filling_s;
    assign bus.lb_wr_en   = wr_en_s;
    assign bus.lb_wr_data = wr_en_s ? bus.src_data : {DW{1'b0}};
    assign bus.lb_rd_en   = rd_en_s;
    assign bus.lb_rd_col  = col_s;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

`ifdef LINE_WINDOW_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;
    logic        stall_ev_s;

    assign stall_ev_s = (filling_s & ~bus.src_valid) | ((state_q == READ) & ~bus.kern_ready);

    // Saturating stall counter, cleared when a frame starts and held while idle.
    always_comb begin
        stall_d = stall_q;
        if (abort) begin
            stall_d = stall_q;
        end else if ((state_q == IDLE) && start) begin
            stall_d = 16'h0000;
        end else if (stall_ev_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'h0001;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    logic unused_s;
    assign unused_s = &{1'b0, fill_cnt_s};
`endif

endmodule

// File: tb/tb_line_window_sched.sv
// Directed bench for line_window_sched (WIDTH=5, HEIGHT=5).
module tb_line_window_sched;

    localparam int WIDTH  = 5;
    localparam int HEIGHT = 5;
    localparam int DW     = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic frame_done;
`ifdef LINE_WINDOW_SCHED_PERF_EN
    logic [15:0] stall_cycles;
`endif

    line_window_sched_if #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DW(DW)) bus_if ();

    line_window_sched #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef LINE_WINDOW_SCHED_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // free-running cycle index
    always @(posedge clk) cyc <= cyc + 1;

    int fr_wr, fr_rd, fd_cnt, fd_cyc, kd_cyc, hold_cnt, viol;
    int ex_cyc, rd1_cyc, wr15_cyc;
    int runs[$];
    int rows[$];
    int last_kind, cur;
    bit prev_rd = 1'b0;

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // mid-cycle observer: event runs, window rows, strobe sanity, win_valid latency
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 1'b0;
        end else begin
            if (bus_if.win_valid !== prev_rd) viol++;
            prev_rd = bus_if.lb_rd_en;
            if (bus_if.lb_wr_en === 1'b1) begin
                if (bus_if.src_ready !== 1'b1 || bus_if.lb_wr_data !== bus_if.src_data) viol++;
                fr_wr++;
                if (fr_wr == 15) wr15_cyc = cyc;
                if (last_kind == 1) cur++;
                else begin
                    if (last_kind == 2) runs.push_back(-cur);
                    last_kind = 1;
                    cur = 1;
                end
            end
            if (bus_if.lb_rd_en === 1'b1) begin
                fr_rd++;
                if (fr_rd == 1) rd1_cyc = cyc;
                if (bus_if.lb_rd_col == 3'd4) ex_cyc = cyc;
                if (last_kind == 2) cur++;
                else begin
                    if (last_kind == 1) runs.push_back(cur);
                    last_kind = 2;
                    cur = 1;
                    rows.push_back(int'(bus_if.win_row));
                end
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (bus_if.kern_ready === 1'b0 && bus_if.lb_rd_col == 3'd2 && busy === 1'b1) hold_cnt++;
        end
    end

    task automatic clear_rec();
        fr_wr = 0; fr_rd = 0; fd_cnt = 0; fd_cyc = -1; kd_cyc = -1;
        hold_cnt = 0; viol = 0; ex_cyc = -100; rd1_cyc = -1; wr15_cyc = -1;
        runs.delete(); rows.delete(); last_kind = 0; cur = 0;
    endtask

    // one frame: tog = src_valid toggles, kst = 4-cycle kern_ready stall at col 2,
    // inj = stray start in READ and stray kern_done in PRIME, abt = abort after 2 refill pixels
    task automatic run_frame(input bit tog, input bit kst, input bit inj, input bit abt);
        int stall_left = 4;
        bit did_start = 1'b0;
        bit did_kd = 1'b0;
        bit did_abt = 1'b0;
        int c0;
        clear_rec();
        bus_if.src_valid = 1'b1;
        bus_if.kern_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c0 = cyc;
        for (int k = 0; k < 400; k++) begin
            if (fd_cnt > 0 || did_abt) break;
            bus_if.src_valid = tog ? ~bus_if.src_valid : 1'b1;
            bus_if.src_data = 8'(8'h30 + k);
            bus_if.kern_ready = 1'b1;
            if (kst && stall_left > 0 && bus_if.lb_rd_col == 3'd2) begin
                bus_if.kern_ready = 1'b0;
                stall_left--;
            end
            bus_if.kern_done = (cyc == ex_cyc + 3);
            if (bus_if.kern_done) kd_cyc = cyc;
            start = 1'b0;
            abort = 1'b0;
            if (inj && !did_start && fr_rd == 2) begin start = 1'b1; did_start = 1'b1; end
            if (inj && !did_kd && cyc == c0 + 4) begin bus_if.kern_done = 1'b1; did_kd = 1'b1; end
            if (abt && !did_abt && fr_wr == 17) begin
                abort = 1'b1;
                bus_if.src_valid = 1'b0;
                did_abt = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        bus_if.kern_done = 1'b0;
        bus_if.src_valid = 1'b1;
        bus_if.kern_ready = 1'b1;
        if (last_kind == 1) runs.push_back(cur);
        else if (last_kind == 2) runs.push_back(-cur);
        last_kind = 0;
    endtask

    task automatic check_frame(input string tag);
        int exp_runs[6] = '{15, -5, 5, -5, 5, -5};
        @(negedge clk);
        chk({tag, ".runs_n"}, runs.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s.run%0d", tag, i), (i < runs.size()) ? runs[i] : 0, exp_runs[i]);
        chk({tag, ".rows_n"}, rows.size(), 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s.row%0d", tag, i), (i < rows.size()) ? rows[i] : -1, i);
        chk({tag, ".frame_done_n"}, fd_cnt, 1);
        chk({tag, ".fd_after_kd"}, fd_cyc - kd_cyc, 1);
        chk({tag, ".wr_total"}, fr_wr, 25);
        chk({tag, ".rd_total"}, fr_rd, 15);
        chk({tag, ".strobe_viol"}, viol, 0);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".frame_done_end"}, frame_done, 0);
    endtask

    initial begin
        bus_if.src_valid = 1'b0;
        bus_if.src_data = 8'h00;
        bus_if.kern_ready = 1'b0;
        bus_if.kern_done = 1'b0;
        clear_rec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.src_ready", bus_if.src_ready, 0);
        chk("rst.rd_en", bus_if.lb_rd_en, 0);
        chk("rst.win_valid", bus_if.win_valid, 0);
        chk("rst.win_row", bus_if.win_row, 0);
        chk("rst.frame_done", frame_done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // baseline frame
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("s1");
`ifdef LINE_WINDOW_SCHED_PERF_EN
        chk("s1.stall", stall_cycles, 0);
`endif

        // src_valid toggling
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check_frame("s2");
        chk("s2.read_after_15th", rd1_cyc - wr15_cyc, 1);

        // kernel back-pressure at column 2
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("s3");
        chk("s3.col_hold", hold_cnt, 4);
`ifdef LINE_WINDOW_SCHED_PERF_EN
        chk("s3.stall", stall_cycles, 4);
`endif

        // abort during refill, then a fresh frame
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("s4.busy_after_abort", busy, 0);
        chk("s4.win_row_after_abort", bus_if.win_row, 0);
        chk("s4.wr_before_abort", fr_wr, 17);
        repeat (10) @(negedge clk);
        chk("s4.no_frame_done", fd_cnt, 0);
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check_frame("s4b");

        // stray start in READ and stray kern_done in PRIME
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check_frame("s5");

        // asynchronous reset in the middle of a read pass
        @(posedge clk); #1;
        clear_rec();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (fr_rd >= 2) break;
            @(posedge clk); #1;
        end
        chk("s6.reached_read", (fr_rd >= 2) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s6.busy", busy, 0);
        chk("s6.frame_done", frame_done, 0);
        chk("s6.src_ready", bus_if.src_ready, 0);
        chk("s6.wr_en", bus_if.lb_wr_en, 0);
        chk("s6.wr_data", bus_if.lb_wr_data, 0);
        chk("s6.rd_en", bus_if.lb_rd_en, 0);
        chk("s6.rd_col", bus_if.lb_rd_col, 0);
        chk("s6.win_valid", bus_if.win_valid, 0);
        chk("s6.win_row", bus_if.win_row, 0);
`ifdef LINE_WINDOW_SCHED_PERF_EN
        chk("s6.stall", stall_cycles, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s6.idle_busy", busy, 0);
        chk("s6.idle_src_ready", bus_if.src_ready, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/line_window_sched.md
Name: line_window_sched

Overview:
- Controller that sequences the 3-row line buffer used by the 3x3 window datapath.
- Accepts a raster pixel stream and gates it into the line buffer: a 3-row prime, then 1-row refills.
- Between fills it issues the WIDTH-column read pass to the downstream kernel and waits for the kernel's done.
- Counts window rows and flags end of frame. Sits between the pixel source and the line buffer / kernel pair.

Parameters:
- WIDTH, 5, image width in pixels (>=3)
- HEIGHT, 5, image height in rows (>=3); window rows per frame = HEIGHT-2
- DW, 8, pixel data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a frame when IDLE
- abort  in  1  synchronous abort; return to IDLE from any state
- src_valid  in  1  source pixel valid
- src_data  in  DW  source pixel
- src_ready  out  1  scheduler accepts pixel this cycle
- lb_wr_en  out  1  line buffer shift-in strobe
- lb_wr_data  out  DW  pixel to line buffer
- lb_rd_en  out  1  line buffer column read strobe
- lb_rd_col  out  $clog2(WIDTH)  column being read
- kern_ready  in  1  kernel can take a column this cycle
- kern_done  in  1  one-cycle pulse; kernel finished current window row
- win_valid  out  1  column data at line buffer output valid (lb_rd_en delayed 1 cycle)
- win_row  out  $clog2(HEIGHT)  current window row index, 0..HEIGHT-3
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0, all counters 0.
- States: IDLE, PRIME, READ, WAIT_DONE, REFILL, FDONE.
- IDLE:
  - src_ready=0.
  - start -> PRIME; fill_cnt=0; win_row=0.
  - start outside IDLE is ignored.
- PRIME:
  - src_ready=1.
  - lb_wr_en = src_valid & src_ready, combinational; lb_wr_data = src_data.
  - Each accepted pixel increments fill_cnt.
  - On acceptance of pixel 3*WIDTH-1 (0-based) -> READ, col=0.
  - src_valid low stalls with no penalty.
- READ:
  - src_ready=0.
  - lb_rd_en = kern_ready; lb_rd_col = col.
  - col increments when lb_rd_en is high.
  - When lb_rd_en is high with col==WIDTH-1 -> WAIT_DONE.
  - kern_ready low holds col.
- WAIT_DONE:
  - No reads or writes.
  - On kern_done: if win_row==HEIGHT-3 -> FDONE; else win_row+1, fill_cnt=0 -> REFILL.
  - kern_done in any other state is ignored.
- REFILL:
  - Same as PRIME, but exits to READ after WIDTH accepted pixels.
- FDONE:
  - frame_done=1 for exactly this cycle -> IDLE.
  - Source pixels beyond WIDTH*HEIGHT are not accepted.
- win_valid is a register of lb_rd_en (1-cycle latency); it is cleared on abort and reset.
- abort:
  - Takes priority over all transitions; next state IDLE.
  - Counters cleared; no frame_done.
  - The line buffer contents are don't-care afterwards.
- abort and start in the same cycle: abort wins; state stays IDLE.
- Counter widths:
  - fill_cnt is $clog2(3*WIDTH) bits, compared against constants.
  - No wrap is ever reached within a legal frame.
- Output registration: src_ready, lb_wr_en and lb_rd_en are decoded from the registered state; all other outputs are registered.

Optional Feature:
- Macro: LINE_WINDOW_SCHED_PERF_EN.
- Defined:
  - Adds output stall_cycles [15:0], which counts cycles in PRIME/REFILL with src_valid=0 plus cycles in READ with kern_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on start in IDLE; held across IDLE.
- Undefined:
  - Port and counter absent.
  - Behaviour is otherwise identical.

Decomposition:
- Package line_window_pkg:
  - state enum (IDLE, PRIME, READ, WAIT_DONE, REFILL, FDONE);
  - localparam helpers PRIME_PIX = 3*WIDTH-style function and counter-width function;
  - default DW.
- One natural sub-module: line_window_ctr, a load/enable/terminal-count counter instantiated for fill_cnt and col.

Test Plan:
- WIDTH=5, HEIGHT=5, src_valid and kern_ready held high, kern_done 3 cycles after each READ exit -> 15 writes, 5 reads, 5 writes, 5 reads, 5 writes, 5 reads; win_row 0,1,2; frame_done a single pulse after the 3rd kern_done; 25 lb_wr_en total.
- src_valid toggling 1/0 during PRIME -> exactly 15 lb_wr_en; READ entered the cycle after the 15th accepted pixel; no write while src_ready=0.
- kern_ready low for 4 cycles at col=2 -> lb_rd_col holds 2; 5 lb_rd_en total; win_valid follows lb_rd_en by exactly 1 cycle.
- abort asserted in REFILL after 2 pixels -> busy=0 next cycle; no frame_done; a fresh start re-primes 15 pixels with win_row=0.
- start pulsed in READ and kern_done pulsed in PRIME -> both ignored; sequence identical to the first scenario.
- rst_n dropped asynchronously mid-READ -> all outputs 0 without a clock edge; IDLE after release. With LINE_WINDOW_SCHED_PERF_EN, stall_cycles=0 after reset and counts 4 for the stall in the third scenario.
